// File: rtl/accumulator_readout_checker_pkg.sv
// Shared definitions for the accumulator readout path: operand/partial-sum widths,
// memory depth derivation and checker FSM encoding.
package accumulator_readout_checker_pkg;

  localparam int unsigned DefSystolicSize    = 8;
  localparam int unsigned DefWeightWidth     = 8;
  localparam int unsigned DefActivationWidth = 8;
  localparam int unsigned DefPatternNumber   = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned calc_psum_width(input int unsigned weight_width,
                                                  input int unsigned activation_width,
                                                  input int unsigned systolic_size);
    return weight_width + activation_width + $clog2(systolic_size);
  endfunction

  function automatic int unsigned calc_depth(input int unsigned pattern_number,
                                             input int unsigned systolic_size);
    return pattern_number * systolic_size;
  endfunction

endpackage

// File: rtl/accumulator_readout_checker_if.sv
// Read/compare bus between the checker, the accumulator memories, the golden store
// and the self-recovery logic.
interface accumulator_readout_checker_if #(
  parameter int unsigned SYSTOLIC_SIZE     = 8,
  parameter int unsigned PARTIAL_SUM_WIDTH = 19,
  parameter int unsigned ADDR_WIDTH        = 3,
  parameter int unsigned COUNT_WIDTH       = 4
);
  logic                                   start;
  logic [ADDR_WIDTH-1:0]                  rd_addr;
  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] acc_data;
  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] golden_data;
  logic                                   busy;
  logic                                   done;
  logic [SYSTOLIC_SIZE-1:0]               fault_map;
  logic                                   first_fail_valid;
  logic [ADDR_WIDTH-1:0]                  first_fail_addr;
  logic [COUNT_WIDTH-1:0]                 fail_count;

  modport master (
    output start, acc_data, golden_data,
    input  rd_addr, busy, done, fault_map, first_fail_valid, first_fail_addr, fail_count
  );

  modport slave (
    input  start, acc_data, golden_data,
    output rd_addr, busy, done, fault_map, first_fail_valid, first_fail_addr, fail_count
  );
endinterface

// File: rtl/accumulator_readout_checker_row_comparator.sv
// Purely combinational per-column equality check of one read-out row against golden.
module accumulator_readout_checker_row_comparator #(
  parameter int unsigned SYSTOLIC_SIZE     = 8,
  parameter int unsigned PARTIAL_SUM_WIDTH = 19
) (
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] acc_data_i,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] golden_data_i,
  output logic [SYSTOLIC_SIZE-1:0]                   mismatch_o
);

  always_comb begin
    mismatch_o = '0;
    for (int c = 0; c < int'(SYSTOLIC_SIZE); c++) begin
      mismatch_o[c] = acc_data_i[c*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] !=
                      golden_data_i[c*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH];
    end
  end

endmodule

// File: rtl/accumulator_readout_checker.sv
// Walks every accumulator address once per pass, compares each row against golden and
// accumulates a sticky per-column fault map, first-fail address and failing-row count.
module accumulator_readout_checker
  import accumulator_readout_checker_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE     = DefSystolicSize,
  parameter int unsigned WEIGHT_WIDTH      = DefWeightWidth,
  parameter int unsigned ACTIVATION_WIDTH  = DefActivationWidth,
  parameter int unsigned PARTIAL_SUM_WIDTH = calc_psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH,
                                                             SYSTOLIC_SIZE),
  parameter int unsigned PATTERN_NUMBER    = DefPatternNumber,
  parameter int unsigned ADDR_WIDTH        = $clog2(PATTERN_NUMBER * SYSTOLIC_SIZE)
) (
  input logic                           clk,
  input logic                           rst,
  accumulator_readout_checker_if.slave  bus
);

  localparam int unsigned DEPTH       = calc_depth(PATTERN_NUMBER, SYSTOLIC_SIZE);
  localparam int unsigned COUNT_WIDTH = $clog2(DEPTH + 1);

  logic [SYSTOLIC_SIZE-1:0] mismatch;

  accumulator_readout_checker_row_comparator #(
    .SYSTOLIC_SIZE     (SYSTOLIC_SIZE),
    .PARTIAL_SUM_WIDTH (PARTIAL_SUM_WIDTH)
  ) u_row_comparator (
    .acc_data_i    (bus.acc_data),
    .golden_data_i (bus.golden_data),
    .mismatch_o    (mismatch)
  );

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [SYSTOLIC_SIZE-1:0] fault_map_q, fault_map_d;
  logic                     ffv_q, ffv_d;
  logic [ADDR_WIDTH-1:0]    ffa_q, ffa_d;
  logic [COUNT_WIDTH-1:0]   fail_count_q, fail_count_d;

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fault_map_d  = fault_map_q;
    ffv_d        = ffv_q;
    ffa_d        = ffa_q;
    fail_count_d = fail_count_q;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d      = StRead;
          rd_addr_d    = '0;
          busy_d       = 1'b1;
          fault_map_d  = '0;
          ffv_d        = 1'b0;
          ffa_d        = '0;
          fail_count_d = '0;
        end
      end
      StRead: begin
        fault_map_d = fault_map_q | mismatch;
        if (|mismatch) begin
          fail_count_d = fail_count_q + COUNT_WIDTH'(1);
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffa_d = rd_addr_q;
          end
        end
        // Explicit wrap keeps the address in range for non-power-of-two depths.
        if (rd_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          rd_addr_d = '0;
          state_d   = StDone;
          done_d    = 1'b1;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_map_q  <= '0;
      ffv_q        <= 1'b0;
      ffa_q        <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_map_q  <= fault_map_d;
      ffv_q        <= ffv_d;
      ffa_q        <= ffa_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign bus.rd_addr          = rd_addr_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.fault_map        = fault_map_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_addr  = ffa_q;
  assign bus.fail_count       = fail_count_q;

endmodule

// File: tb/tb_accumulator_readout_checker.sv
// Randomized bench: memories and golden store modelled as arrays, results predicted by
// scanning the arrays directly.
module tb_accumulator_readout_checker;

  localparam int unsigned SS    = 8;
  localparam int unsigned PSW   = 19;
  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accumulator_readout_checker_if #(
    .SYSTOLIC_SIZE     (SS),
    .PARTIAL_SUM_WIDTH (PSW),
    .ADDR_WIDTH        (AW),
    .COUNT_WIDTH       (CW)
  ) bus_if ();

  logic [SS*PSW-1:0] acc_mem  [DEPTH];
  logic [SS*PSW-1:0] gold_mem [DEPTH];

  assign bus_if.acc_data    = acc_mem[bus_if.rd_addr];
  assign bus_if.golden_data = gold_mem[bus_if.rd_addr];

  accumulator_readout_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [SS-1:0] exp_map;
  logic          exp_ffv;
  logic [AW-1:0] exp_ffa;
  logic [CW-1:0] exp_cnt;

  task automatic fill_clean();
    for (int a = 0; a < int'(DEPTH); a++) begin
      for (int c = 0; c < int'(SS); c++) gold_mem[a][c*PSW +: PSW] = PSW'($urandom());
      acc_mem[a] = gold_mem[a];
    end
  endtask

  task automatic compute_expected();
    bit row_bad;
    exp_map = '0; exp_ffv = 1'b0; exp_ffa = '0; exp_cnt = '0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      row_bad = 1'b0;
      for (int c = 0; c < int'(SS); c++) begin
        if (acc_mem[a][c*PSW +: PSW] !== gold_mem[a][c*PSW +: PSW]) begin
          exp_map[c] = 1'b1;
          row_bad    = 1'b1;
        end
      end
      if (row_bad) begin
        if (!exp_ffv) begin
          exp_ffv = 1'b1;
          exp_ffa = AW'(a);
        end
        exp_cnt = exp_cnt + CW'(1);
      end
    end
  endtask

  task automatic check_results(input string name);
    compute_expected();
    checks++;
    if (bus_if.fault_map !== exp_map || bus_if.fail_count !== exp_cnt ||
        bus_if.first_fail_valid !== exp_ffv ||
        (exp_ffv && bus_if.first_fail_addr !== exp_ffa)) begin
      failures++;
      $display("FAIL %s: got map=%h cnt=%0d ffv=%b ffa=%0d, want map=%h cnt=%0d ffv=%b ffa=%0d",
               name, bus_if.fault_map, bus_if.fail_count, bus_if.first_fail_valid,
               bus_if.first_fail_addr, exp_map, exp_cnt, exp_ffv, exp_ffa);
    end
  endtask

  // Starts a pass from IDLE at a negedge; optionally pokes start mid-READ and in DONE.
  task automatic run_pass(input string name, input bit start_in_read, input bit start_in_done);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    checks++;
    if (bus_if.fault_map !== '0 || bus_if.fail_count !== '0 || bus_if.first_fail_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s start_clear: got map=%h cnt=%0d ffv=%b, want 0 0 0", name,
               bus_if.fault_map, bus_if.fail_count, bus_if.first_fail_valid);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      checks++;
      if (bus_if.rd_addr !== AW'(i) || bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
        failures++;
        $display("FAIL %s read_seq[%0d]: got addr=%0d busy=%b done=%b, want addr=%0d busy=1 done=0",
                 name, i, bus_if.rd_addr, bus_if.busy, bus_if.done, i);
      end
      if (start_in_read && i == 3) bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b1 || bus_if.rd_addr !== '0) begin
      failures++;
      $display("FAIL %s done_pulse: got done=%b busy=%b addr=%0d, want done=1 busy=1 addr=0",
               name, bus_if.done, bus_if.busy, bus_if.rd_addr);
    end
    if (start_in_done) bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
        failures++;
        $display("FAIL %s idle_after[%0d]: got done=%b busy=%b, want done=0 busy=0",
                 name, k, bus_if.done, bus_if.busy);
      end
      if (k == 0) @(negedge clk);
    end
    check_results(name);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus_if.rd_addr !== '0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 ||
        bus_if.fault_map !== '0 || bus_if.first_fail_valid !== 1'b0 ||
        bus_if.first_fail_addr !== '0 || bus_if.fail_count !== '0) begin
      failures++;
      $display("FAIL %s: got addr=%0d busy=%b done=%b map=%h ffv=%b ffa=%0d cnt=%0d, want all 0",
               name, bus_if.rd_addr, bus_if.busy, bus_if.done, bus_if.fault_map,
               bus_if.first_fail_valid, bus_if.first_fail_addr, bus_if.fail_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    fill_clean();
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    fill_clean();
    run_pass("clean", 1'b0, 1'b0);
  endtask

  task automatic test_stuck_column();
    fill_clean();
    for (int a = 0; a < int'(DEPTH); a++) acc_mem[a][3*PSW +: PSW] = gold_mem[a][3*PSW +: PSW] ^ 19'h00001;
    run_pass("stuck_col3", 1'b0, 1'b0);
  endtask

  task automatic test_sparse();
    fill_clean();
    acc_mem[5][0*PSW +: PSW] = ~gold_mem[5][0*PSW +: PSW];
    acc_mem[2][7*PSW +: PSW] = gold_mem[2][7*PSW +: PSW] + 19'd1;
    run_pass("sparse", 1'b0, 1'b0);
  endtask

  task automatic test_msb();
    fill_clean();
    acc_mem[7][6*PSW + PSW - 1] = ~gold_mem[7][6*PSW + PSW - 1];
    run_pass("msb_only", 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    test_stuck_column();
    repeat (3) @(negedge clk);
    check_results("idle_hold");
    fill_clean();
    run_pass("start_ignored", 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    fill_clean();
    acc_mem[0][1*PSW +: PSW] = gold_mem[0][1*PSW +: PSW] ^ 19'h40000;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus_if.rd_addr !== AW'(4) || bus_if.fault_map !== 8'h02) begin
      failures++;
      $display("FAIL pre_reset: got addr=%0d map=%h, want addr=4 map=02",
               bus_if.rd_addr, bus_if.fault_map);
    end
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_clean();
    run_pass("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      fill_clean();
      for (int a = 0; a < int'(DEPTH); a++)
        for (int c = 0; c < int'(SS); c++)
          if ($urandom_range(7) == 0) acc_mem[a][c*PSW + int'($urandom_range(PSW - 1))] ^= 1'b1;
      run_pass($sformatf("random%0d", it), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck_column();
    test_sparse();
    test_msb();
    test_ignored_start();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
